pattern_adc_decoder: RTL and testbench

PATTERN_ADC_DECODER -- requirements
Module: pattern_adc_decoder

---
 rtl/pattern_adc_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_pattern_adc_decoder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_adc_decoder.sv
// ---------------------------------------------------------------------------
// pattern_adc_decoder
//   Slices an ADC sample stream against a threshold and decodes framed,
//   fixed-rate pulse patterns. A frame starts on the first high level, is
//   sampled once per bit period at mid-bit, and ends after a run of
//   gap_min low cycles. Bits past _PAT_WIDTH are not stored; any high seen
//   after the pattern is full flags the frame as overrun.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   rx_en      decoder enable; low aborts the current frame and idles
//   adc_data   unsigned ADC sample, one per cycle
//   threshold  slicing level (high when adc_data >= threshold)
//   duty_num   bit period minus one, in cycles
//   gap_min    low-run length that terminates a frame (1..65535)
//   pat_out    last decoded pattern, LSB is the first bit received
//   frame_cnt  frames decoded since rx_en rose, saturating at 255
//   rx_level   registered sliced level
//   busy       high while receiving a frame or waiting out its gap
//   valid      one-cycle strobe when pat_out updates
//   err        one-cycle strobe with valid when the frame overran
// ---------------------------------------------------------------------------
module pattern_adc_decoder #(
    parameter int _PAT_WIDTH = 8,
    parameter int _ADC_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_en,
    input  logic [_ADC_WIDTH-1:0] adc_data,
    input  logic [_ADC_WIDTH-1:0] threshold,
    input  logic [7:0]            duty_num,
    input  logic [15:0]           gap_min,
    output logic [_PAT_WIDTH-1:0] pat_out,
    output logic [7:0]            frame_cnt,
    output logic                  rx_level,
    output logic                  busy,
    output logic                  valid,
    output logic                  err
);

    // bit_idx must be able to hold _PAT_WIDTH itself (the "pattern full" value)
    localparam int IDX_W = $clog2(_PAT_WIDTH + 1);
    localparam logic [_PAT_WIDTH-1:0] PAT_ONE  = _PAT_WIDTH'(1'b1);
    localparam logic [_PAT_WIDTH-1:0] PAT_ZERO = {_PAT_WIDTH{1'b0}};
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0]      IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]      IDX_FULL = IDX_W'(_PAT_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_RECV = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                  state_r;
    logic                    bit_in_q_r;
    logic                    rx_en_q_r;
    logic [7:0]              phase_cnt_r;
    logic [IDX_W-1:0]        bit_idx_r;
    logic [15:0]             low_run_r;
    logic [_PAT_WIDTH-1:0]   shift_r;
    logic                    ovr_r;
    logic [_PAT_WIDTH-1:0]   pat_out_r;
    logic [7:0]              frame_cnt_r;
    logic                    busy_r;
    logic                    valid_r;
    logic                    err_r;

    logic [15:0]             low_run_nxt_s;
    logic                    gap_hit_s;
    logic                    phase_last_s;
    logic [7:0]              phase_nxt_s;
    logic [IDX_W-1:0]        bit_idx_nxt_s;
    logic                    full_s;
    logic [_PAT_WIDTH-1:0]   bit_mask_s;
    logic [_PAT_WIDTH-1:0]   shift_nxt_s;
    logic [7:0]              frame_cnt_inc_s;
    logic                    rx_rise_s;

    // Next-value arithmetic shared by WAIT (first cycle of a frame) and RECV
    always_comb begin
        low_run_nxt_s   = bit_in_q_r ? 16'd0
                        : ((low_run_r == 16'hFFFF) ? 16'hFFFF : low_run_r + 16'd1);
        gap_hit_s       = (low_run_nxt_s == gap_min);
        phase_last_s    = (phase_cnt_r == duty_num);
        phase_nxt_s     = phase_last_s ? 8'd0 : phase_cnt_r + 8'd1;
        bit_idx_nxt_s   = phase_last_s ? bit_idx_r + IDX_ONE : bit_idx_r;
        full_s          = (bit_idx_nxt_s == IDX_FULL);
        bit_mask_s      = PAT_ONE << bit_idx_r;
        // mid-bit sample point is duty_num/2
        shift_nxt_s     = (phase_cnt_r == {1'b0, duty_num[7:1]})
                        ? ((shift_r & ~bit_mask_s) | (bit_in_q_r ? bit_mask_s : PAT_ZERO))
                        : shift_r;
        frame_cnt_inc_s = (frame_cnt_r == 8'hFF) ? 8'hFF : frame_cnt_r + 8'd1;
        rx_rise_s       = rx_en & ~rx_en_q_r;
    end

    // Input slicer and enable edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_in_q_r <= 1'b0;
            rx_en_q_r  <= 1'b0;
        end else begin
            bit_in_q_r <= (adc_data >= threshold);
            rx_en_q_r  <= rx_en;
        end
    end

    // Frame FSM with its datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            phase_cnt_r <= 8'd0;
            bit_idx_r   <= IDX_ZERO;
            low_run_r   <= 16'd0;
            shift_r     <= PAT_ZERO;
            ovr_r       <= 1'b0;
            pat_out_r   <= PAT_ZERO;
            frame_cnt_r <= 8'd0;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            if (rx_rise_s) begin
                frame_cnt_r <= 8'd0;
            end
            if (!rx_en) begin
                // abort: drop the frame silently, keep pat_out and frame_cnt
                state_r     <= ST_IDLE;
                phase_cnt_r <= 8'd0;
                bit_idx_r   <= IDX_ZERO;
                low_run_r   <= 16'd0;
                shift_r     <= PAT_ZERO;
                ovr_r       <= 1'b0;
                busy_r      <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        phase_cnt_r <= 8'd0;
                        bit_idx_r   <= IDX_ZERO;
                        low_run_r   <= 16'd0;
                        shift_r     <= PAT_ZERO;
                        ovr_r       <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        // counters are already zero here, so the first high
                        // cycle is processed as phase 0 of bit 0
                        if (bit_in_q_r) begin
                            phase_cnt_r <= phase_nxt_s;
                            bit_idx_r   <= bit_idx_nxt_s;
                            shift_r     <= shift_nxt_s;
                            low_run_r   <= low_run_nxt_s;
                            busy_r      <= 1'b1;
                            state_r     <= full_s ? ST_GAP : ST_RECV;
                        end else begin
                            busy_r      <= 1'b0;
                        end
                    end
                    ST_RECV: begin
                        phase_cnt_r <= phase_nxt_s;
                        bit_idx_r   <= bit_idx_nxt_s;
                        shift_r     <= shift_nxt_s;
                        low_run_r   <= low_run_nxt_s;
                        // end of frame has priority over pattern full
                        if (gap_hit_s) begin
                            busy_r  <= 1'b0;
                            state_r <= ST_DONE;
                        end else if (full_s) begin
                            busy_r  <= 1'b1;
                            state_r <= ST_GAP;
                        end else begin
                            busy_r  <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        low_run_r <= low_run_nxt_s;
                        ovr_r     <= ovr_r | bit_in_q_r;
                        if (gap_hit_s) begin
                            busy_r  <= 1'b0;
                            state_r <= ST_DONE;
                        end else begin
                            busy_r  <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        pat_out_r   <= shift_r;
                        valid_r     <= 1'b1;
                        err_r       <= ovr_r;
                        ovr_r       <= 1'b0;
                        frame_cnt_r <= frame_cnt_inc_s;
                        phase_cnt_r <= 8'd0;
                        bit_idx_r   <= IDX_ZERO;
                        low_run_r   <= 16'd0;
                        shift_r     <= PAT_ZERO;
                        busy_r      <= 1'b0;
                        state_r     <= ST_WAIT;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign pat_out   = pat_out_r;
    assign frame_cnt = frame_cnt_r;
    assign rx_level  = bit_in_q_r;
    assign busy      = busy_r;
    assign valid     = valid_r;
    assign err       = err_r;

endmodule

// File: tb/tb_pattern_adc_decoder.sv
// ---------------------------------------------------------------------------
// tb_pattern_adc_decoder
//   Drives sliced-level streams into pattern_adc_decoder and checks every
//   valid strobe against expected frames. Expected frames come either from
//   fixed values or from a stream-level reference model that finds frame
//   starts, frame ends (gap_min consecutive lows) and mid-bit sample times.
// ---------------------------------------------------------------------------
module tb_pattern_adc_decoder;

    localparam int PW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_en;
    logic [AW-1:0] adc_data;
    logic [AW-1:0] threshold;
    logic [7:0]    duty_num;
    logic [15:0]   gap_min;
    logic [PW-1:0] pat_out;
    logic [7:0]    frame_cnt;
    logic          rx_level;
    logic          busy;
    logic          valid;
    logic          err;

    typedef struct {
        logic [7:0] pat;
        logic       err;
    } exp_t;

    int    n_vec = 0;
    int    n_err = 0;
    bit    stim_q[$];
    exp_t  exp_q[$];
    exp_t  mon_e;
    int    model_frames = 0;
    logic [7:0] last_pat = 8'h00;
    bit    eq_mode = 1'b0;

    pattern_adc_decoder #(._PAT_WIDTH(PW), ._ADC_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_en     (rx_en),
        .adc_data  (adc_data),
        .threshold (threshold),
        .duty_num  (duty_num),
        .gap_min   (gap_min),
        .pat_out   (pat_out),
        .frame_cnt (frame_cnt),
        .rx_level  (rx_level),
        .busy      (busy),
        .valid     (valid),
        .err       (err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every valid strobe must match the oldest expected frame
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_valid", 32'(valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("pat_out", 32'(pat_out), 32'(mon_e.pat));
                    check_val("err", 32'(err), 32'(mon_e.err));
                end
            end else if (err) begin
                check_val("err_without_valid", 32'(err), 32'd0);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [7:0] pat, input logic e);
        exp_t x;
        x.pat = pat;
        x.err = e;
        exp_q.push_back(x);
        model_frames++;
        last_pat = pat;
    endtask

    task automatic add_lows(input int n);
        for (int i = 0; i < n; i++) stim_q.push_back(1'b0);
    endtask

    task automatic add_bits(input logic [15:0] bits, input int nbits, input int d);
        for (int k = 0; k < nbits; k++)
            for (int c = 0; c <= d; c++) stim_q.push_back(bits[k]);
    endtask

    // Stream-level reference: frames start on a high, end when gap_min
    // consecutive lows are seen, and are blind for one cycle after ending
    task automatic model_stream(input int d, input int g);
        int n, t, t0, tend, run, s;
        logic [7:0] pat;
        logic e;
        n = stim_q.size();
        t = 0;
        while (t < n) begin
            t0 = -1;
            for (int i = t; i < n; i++) begin
                if (stim_q[i]) begin t0 = i; break; end
            end
            if (t0 < 0) break;
            tend = -1;
            run = 0;
            for (int i = t0; i < n; i++) begin
                run = stim_q[i] ? 0 : run + 1;
                if (run == g) begin tend = i; break; end
            end
            if (tend < 0) break;
            pat = 8'h00;
            for (int k = 0; k < PW; k++) begin
                s = t0 + k * (d + 1) + d / 2;
                if (s <= tend && stim_q[s]) pat[k] = 1'b1;
            end
            e = 1'b0;
            for (int i = t0 + PW * (d + 1); i <= tend; i++) if (stim_q[i]) e = 1'b1;
            push_exp(pat, e);
            t = tend + 2;
        end
    endtask

    task automatic drive_level(input bit lv);
        @(posedge clk);
        #1;
        if (lv) adc_data = eq_mode ? threshold : 8'($urandom_range(32'(threshold), 255));
        else    adc_data = 8'($urandom_range(0, 32'(threshold) - 1));
    endtask

    task automatic set_cfg(input int d, input int g);
        @(posedge clk);
        #1;
        adc_data = 8'h00;
        duty_num = 8'(d);
        gap_min  = 16'(g);
    endtask

    // Apply stim_q, wait (bounded) for all expected frames, check frame_cnt
    task automatic run_stream(input bit use_model, input int d, input int g);
        int budget;
        if (use_model) model_stream(d, g);
        foreach (stim_q[i]) drive_level(stim_q[i]);
        @(posedge clk);
        #1;
        adc_data = 8'h00;
        budget = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        check_val("frames_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        stim_q.delete();
        repeat (2) @(negedge clk);
        check_val("frame_cnt", 32'(frame_cnt), (model_frames > 255) ? 32'd255 : 32'(model_frames));
    endtask

    task automatic restart();
        @(posedge clk);
        #1;
        rx_en    = 1'b0;
        adc_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rx_en = 1'b1;
        repeat (3) @(posedge clk);
        model_frames = 0;
        @(negedge clk);
        check_val("restart_frame_cnt", 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        int d, g, nb;
        logic [15:0] bits;

        rst_n     = 1'b0;
        rx_en     = 1'b0;
        adc_data  = 8'h00;
        threshold = 8'h80;
        duty_num  = 8'd3;
        gap_min   = 16'd10;
        #12;
        check_val("rst_pat_out", 32'(pat_out), 32'd0);
        check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_val("rst_rx_level", 32'(rx_level), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        restart();

        // basic frame 1,1,0,1 at 4 cycles per bit
        set_cfg(3, 10);
        add_lows(3); add_bits(16'h000B, 4, 3); add_lows(14);
        push_exp(8'h0B, 1'b0);
        run_stream(1'b0, 3, 10);
        check_val("basic_pat", 32'(pat_out), 32'h0B);
        check_val("basic_cnt", 32'(frame_cnt), 32'd1);

        // back-to-back frames
        restart();
        set_cfg(1, 20);
        add_lows(3); add_bits(16'h0005, 3, 1); add_lows(30);
        add_bits(16'h0081, 8, 1); add_lows(24);
        push_exp(8'h05, 1'b0);
        push_exp(8'h81, 1'b0);
        run_stream(1'b0, 1, 20);
        check_val("b2b_cnt", 32'(frame_cnt), 32'd2);

        // overrun: ten high bits into an eight-bit pattern
        restart();
        set_cfg(1, 8);
        add_lows(3); add_bits(16'h03FF, 10, 1); add_lows(12);
        push_exp(8'hFF, 1'b1);
        run_stream(1'b0, 1, 8);

        // adc_data exactly at threshold slices high
        eq_mode = 1'b1;
        set_cfg(2, 6);
        add_lows(3); add_bits(16'h000D, 4, 2); add_lows(10);
        push_exp(8'h0D, 1'b0);
        run_stream(1'b0, 2, 6);
        eq_mode = 1'b0;

        // one bit per cycle
        set_cfg(0, 3);
        add_lows(3); add_bits(16'h002D, 8, 0); add_lows(7);
        push_exp(8'h2D, 1'b0);
        run_stream(1'b0, 0, 3);
        check_val("duty0_pat", 32'(pat_out), 32'h2D);

        // asynchronous reset in the middle of a frame
        set_cfg(1, 10);
        drive_level(1'b0); drive_level(1'b0);
        for (int i = 0; i < 5; i++) drive_level(1'b1);
        @(negedge clk);
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_pat_out", 32'(pat_out), 32'd0);
        check_val("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_val("arst_rx_level", 32'(rx_level), 32'd0);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_valid", 32'(valid), 32'd0);
        check_val("arst_err", 32'(err), 32'd0);
        adc_data = 8'h00;
        exp_q.delete();
        model_frames = 0;
        last_pat = 8'h00;
        #23;
        rst_n = 1'b1;
        set_cfg(2, 4);
        add_lows(3); add_bits(16'h00B5, 8, 2); add_lows(8);
        push_exp(8'hB5, 1'b0);
        run_stream(1'b0, 2, 4);
        check_val("post_rst_cnt", 32'(frame_cnt), 32'd1);

        // abort in the middle of bit 3
        restart();
        set_cfg(3, 10);
        drive_level(1'b0); drive_level(1'b0);
        for (int b = 0; b < 3; b++)
            for (int c = 0; c < 4; c++) drive_level((b != 1) ? 1'b1 : 1'b0);
        drive_level(1'b1); drive_level(1'b1);
        @(negedge clk);
        check_val("abort_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rx_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_busy_after", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check_val("abort_pat_hold", 32'(pat_out), 32'(last_pat));
        check_val("abort_cnt_hold", 32'(frame_cnt), 32'd0);

        // frame counter saturation over 260 frames
        restart();
        set_cfg(0, 1);
        add_lows(2);
        for (int f = 0; f < 260; f++) begin
            add_bits(16'h0001, 1, 0);
            add_lows(2);
        end
        add_lows(4);
        run_stream(1'b1, 0, 1);
        check_val("sat_cnt", 32'(frame_cnt), 32'd255);

        // randomized scenarios against the reference model
        restart();
        for (int sc = 0; sc < 8; sc++) begin
            d = int'($urandom_range(0, 3));
            g = int'($urandom_range(1, 24));
            set_cfg(d, g);
            threshold = 8'($urandom_range(1, 255));
            for (int f = 0; f < 3; f++) begin
                add_lows(int'($urandom_range(0, 32'(g + 3))));
                nb   = int'($urandom_range(1, 11));
                bits = 16'($urandom()) | 16'h0001;
                add_bits(bits, nb, d);
            end
            add_lows(g + 4);
            run_stream(1'b1, d, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
